microop_sequencer: RTL and testbench

Control-path stage that owns the opcode register and the micro-op counter. It drives the microcode address {opcode, count} and consumes the 32-bit control word returned combinationally for that address. It decodes the control word into the datapath's register index, active-low output-enable and write-strobe lines, and advances or resets the sequence each clock. It sits between the opword register/bus and the microcode store, and is the sole writer of microcode ADDR.

---
 rtl/microop_sequencer_pkg.sv | 58 +++++
 rtl/microop_sequencer_if.sv | 29 ++
 rtl/microop_sequencer_plane_decoder.sv | 20 ++
 rtl/microop_sequencer.sv | 103 ++++++++++
 tb/tb_microop_sequencer.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/microop_sequencer_pkg.sv
// Shared definitions for the microcode store and the micro-op sequencer:
// opcode values, control-word field positions and field encodings.
package microop_sequencer_pkg;

  localparam int OPCODE_W = 6;
  localparam int COUNT_W  = 5;
  localparam int ADDR_W   = OPCODE_W + COUNT_W;
  localparam int UCODE_W  = 32;

  // Opcodes (upper microcode address bits)
  localparam logic [OPCODE_W-1:0] OP_RESET = 6'd0;
  localparam logic [OPCODE_W-1:0] OP_FETCH = 6'd1;
  localparam logic [OPCODE_W-1:0] OP_LHU   = 6'd2;

  // Control-word field positions
  localparam int CW_CTRL_DATA_LSB  = 0;
  localparam int CW_CTRL_DATA_W    = 6;
  localparam int CW_REG_SEL_LSB    = 6;
  localparam int CW_REG_SEL_W      = 2;
  localparam int CW_OUT_PLANE_LSB  = 8;
  localparam int CW_OUT_PLANE_W    = 4;
  localparam int CW_IN_PLANE_LSB   = 12;
  localparam int CW_IN_PLANE_W     = 3;
  localparam int CW_MISC_BIT       = 15;
  localparam int CW_OPCODE_SEL_BIT = 22;

  // Register index source
  typedef enum logic [CW_REG_SEL_W-1:0] {
    REG_SEL_RS   = 2'd0,  // OPWORD[25:21]
    REG_SEL_RT   = 2'd1,  // OPWORD[20:16]
    REG_SEL_RD   = 2'd2,  // OPWORD[15:11]
    REG_SEL_CTRL = 2'd3   // ctrl_data[4:0]
  } reg_sel_e;

  // Bus-driver planes (0 = nobody drives; 10..15 also drive nothing)
  localparam int                        N_OUT_PLANES = 10;
  localparam logic [CW_OUT_PLANE_W-1:0] OUT_NONE     = 4'd0;
  localparam logic [CW_OUT_PLANE_W-1:0] OUT_REG      = 4'd1;

  // Write-strobe planes; 4 and 7 have no strobe
  localparam int                       N_IN_PLANES    = 7;
  localparam logic [CW_IN_PLANE_W-1:0] IN_NONE        = 3'd0;
  localparam logic [CW_IN_PLANE_W-1:0] IN_REG         = 3'd1;
  localparam logic [CW_IN_PLANE_W-1:0] IN_NO_STROBE_4 = 3'd4;
  localparam logic [CW_IN_PLANE_W-1:0] IN_OPCODE      = 3'd6;
  localparam logic [CW_IN_PLANE_W-1:0] IN_NO_STROBE_7 = 3'd7;

  localparam logic MISC_RESET_MICROOP_COUNTER = 1'b1;

  localparam logic OPCODE_SEL_OPWORD = 1'b0;
  localparam logic OPCODE_SEL_BUS    = 1'b1;

  function automatic logic [ADDR_W-1:0] make_addr(input logic [OPCODE_W-1:0] opcode,
                                                  input logic [COUNT_W-1:0]  count);
    return {opcode, count};
  endfunction

endpackage

// File: rtl/microop_sequencer_if.sv
// Bundle between the sequencer, the microcode store and the datapath.
// Flow control: there is no valid/ready pair. The sequencer advances on every
// rising CLK edge where N_RDY=0 and N_BOOTED=0; if either is high the edge is
// a hold (state kept, write strobes suppressed). UCODE must be valid for the
// current ADDR within the same cycle.
interface microop_sequencer_if;
  import microop_sequencer_pkg::*;

  logic [ADDR_W-1:0]       ADDR;
  logic [UCODE_W-1:0]      UCODE;
  logic [31:0]             OPWORD;
  logic [31:0]             BUS;
  logic                    N_BOOTED;
  logic                    N_RDY;
  logic [4:0]              REG_IDX;
  logic [N_OUT_PLANES-1:0] N_OUT;
  logic [N_IN_PLANES-1:0]  N_IN;
  logic                    FAULT;

  modport master (
    output ADDR, REG_IDX, N_OUT, N_IN, FAULT,
    input  UCODE, OPWORD, BUS, N_BOOTED, N_RDY
  );

  modport slave (
    input  ADDR, REG_IDX, N_OUT, N_IN, FAULT,
    output UCODE, OPWORD, BUS, N_BOOTED, N_RDY
  );
endinterface

// File: rtl/microop_sequencer_plane_decoder.sv
// N-way one-hot active-low decoder. Select 0 and selects >= N decode to all
// ones, so bit 0 is never driven low.
module plane_decoder #(
  parameter int N     = 10,
  parameter int SEL_W = 4
) (
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output logic [N-1:0]     n_out
);

  // Pull the selected line low when enabled
  always_comb begin
    n_out = '1;
    for (int k = 1; k < N; k++) begin
      if (en && (sel == SEL_W'(k))) n_out[k] = 1'b0;
    end
  end

endmodule

// File: rtl/microop_sequencer.sv
// Micro-op sequencer: owns the opcode register and micro-op counter, drives
// the microcode address and decodes the returned control word into register
// index, bus-driver enables and write strobes.
module microop_sequencer
  import microop_sequencer_pkg::*;
(
  input  logic                CLK,
  input  logic                N_RST,
  microop_sequencer_if.master sif
);

  logic [OPCODE_W-1:0]       opcode_q, opcode_d;
  logic [COUNT_W-1:0]        count_q, count_d;
  logic                      fault_q, fault_d;

  logic [CW_CTRL_DATA_W-1:0] ctrl_data;
  reg_sel_e                  reg_sel;
  logic [CW_OUT_PLANE_W-1:0] out_plane;
  logic [CW_IN_PLANE_W-1:0]  in_plane;
  logic                      misc;
  logic                      opcode_sel;
  logic                      hold;
  logic                      in_en;

  assign ctrl_data  = sif.UCODE[CW_CTRL_DATA_LSB +: CW_CTRL_DATA_W];
  assign reg_sel    = reg_sel_e'(sif.UCODE[CW_REG_SEL_LSB +: CW_REG_SEL_W]);
  assign out_plane  = sif.UCODE[CW_OUT_PLANE_LSB +: CW_OUT_PLANE_W];
  assign in_plane   = sif.UCODE[CW_IN_PLANE_LSB +: CW_IN_PLANE_W];
  assign misc       = sif.UCODE[CW_MISC_BIT];
  assign opcode_sel = sif.UCODE[CW_OPCODE_SEL_BIT];

  assign hold = sif.N_RDY | sif.N_BOOTED;

  // Register-file index from the opword fields or the control word literal
  always_comb begin
    sif.REG_IDX = sif.OPWORD[25:21];
    case (reg_sel)
      REG_SEL_RS:   sif.REG_IDX = sif.OPWORD[25:21];
      REG_SEL_RT:   sif.REG_IDX = sif.OPWORD[20:16];
      REG_SEL_RD:   sif.REG_IDX = sif.OPWORD[15:11];
      REG_SEL_CTRL: sif.REG_IDX = ctrl_data[4:0];
      default:      sif.REG_IDX = sif.OPWORD[25:21];
    endcase
  end

  // Next opcode/counter/fault; overflow wins over an opcode load
  always_comb begin
    opcode_d = opcode_q;
    count_d  = count_q;
    fault_d  = fault_q;
    if (!hold) begin
      if (in_plane == IN_OPCODE) begin
        opcode_d = (opcode_sel == OPCODE_SEL_BUS) ? sif.BUS[5:0] : sif.OPWORD[31:26];
      end
      if (misc == MISC_RESET_MICROOP_COUNTER) begin
        count_d = '0;
      end else if (count_q == '1) begin
        count_d  = '0;
        opcode_d = OP_RESET;
        fault_d  = 1'b1;
      end else begin
        count_d = count_q + COUNT_W'(1);
      end
    end
  end

  // Sequencer state; reset abandons any sequence immediately
  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      opcode_q <= OP_RESET;
      count_q  <= '0;
      fault_q  <= 1'b0;
    end else begin
      opcode_q <= opcode_d;
      count_q  <= count_d;
      fault_q  <= fault_d;
    end
  end

  assign sif.ADDR  = make_addr(opcode_q, count_q);
  assign sif.FAULT = fault_q;

  // Bus drivers stay on through a stall; strobes need a non-held cycle
  assign in_en = N_RST & ~hold & (in_plane != IN_NO_STROBE_4);

  plane_decoder #(.N(N_OUT_PLANES), .SEL_W(CW_OUT_PLANE_W)) u_out_dec (
    .en    (N_RST),
    .sel   (out_plane),
    .n_out (sif.N_OUT)
  );

  plane_decoder #(.N(N_IN_PLANES), .SEL_W(CW_IN_PLANE_W)) u_in_dec (
    .en    (in_en),
    .sel   (in_plane),
    .n_out (sif.N_IN)
  );

  // Control-word and bus bits consumed elsewhere
  logic unused_ok;
  assign unused_ok = ^{sif.UCODE[31:23], sif.UCODE[21:16], ctrl_data[5],
                       sif.BUS[31:6], sif.OPWORD[10:0]};

endmodule

// File: tb/tb_microop_sequencer.sv
// Directed bench for microop_sequencer: a combinational decode table followed
// by hand-written boot, fetch, stall, overflow and async-reset sequences.
module tb_microop_sequencer;
  import microop_sequencer_pkg::*;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic N_RST = 1'b0;
  always #5 CLK = ~CLK;

  microop_sequencer_if sif ();

  logic        use_model = 1'b0;
  logic [31:0] ucode_force = 32'h0;
  logic [31:0] opword = 32'h0;
  logic [31:0] bus = 32'h0;
  logic        n_booted = 1'b0;
  logic        n_rdy = 1'b0;

  // Small microcode image: RESET -> FETCH -> opcode from OPWORD
  function automatic logic [31:0] model_ucode(input logic [10:0] a);
    logic [31:0] w;
    w = 32'h0;
    case (a)
      11'h000: w = 32'h0000_1000;  // in_plane 1
      11'h001: w = 32'h0040_E000;  // misc, in_plane 6, opcode from BUS
      11'h022: w = 32'h0000_0300;  // out_plane 3
      11'h024: w = 32'h0000_E000;  // misc, in_plane 6, opcode from OPWORD
      11'h040: w = 32'h0000_1000;  // reg_sel 0, in_plane 1
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  assign sif.UCODE    = use_model ? model_ucode(sif.ADDR) : ucode_force;
  assign sif.OPWORD   = opword;
  assign sif.BUS      = bus;
  assign sif.N_BOOTED = n_booted;
  assign sif.N_RDY    = n_rdy;

  microop_sequencer dut (
    .CLK   (CLK),
    .N_RST (N_RST),
    .sif   (sif)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic [31:0] ucode;
    logic [31:0] opword;
    logic        n_rdy;
    logic        n_booted;
    logic [4:0]  reg_idx;
    logic [9:0]  n_out;
    logic [6:0]  n_in;
  } vec_t;

  vec_t vecs[14];

  initial begin
    // ---- decode table (hand-computed) ----
    vecs[0]  = '{32'h0000_00DF, 32'h0000_0000, 1'b0, 1'b0, 5'd31, 10'h3FF, 7'h7F}; // reg_sel 3, ctrl 31
    vecs[1]  = '{32'h0000_0040, 32'h0005_0000, 1'b0, 1'b0, 5'd5,  10'h3FF, 7'h7F}; // reg_sel 1
    vecs[2]  = '{32'h0000_0000, 32'h0843_1234, 1'b0, 1'b0, 5'd2,  10'h3FF, 7'h7F}; // reg_sel 0
    vecs[3]  = '{32'h0000_0080, 32'h0000_A800, 1'b0, 1'b0, 5'd21, 10'h3FF, 7'h7F}; // reg_sel 2
    vecs[4]  = '{32'h0000_0100, 32'h0000_0000, 1'b0, 1'b0, 5'd0,  10'h3FD, 7'h7F}; // out 1
    vecs[5]  = '{32'h0000_0900, 32'h0000_0000, 1'b0, 1'b0, 5'd0,  10'h1FF, 7'h7F}; // out 9
    vecs[6]  = '{32'h0000_0A00, 32'h0000_0000, 1'b0, 1'b0, 5'd0,  10'h3FF, 7'h7F}; // out 10
    vecs[7]  = '{32'h0000_0F00, 32'h0000_0000, 1'b0, 1'b0, 5'd0,  10'h3FF, 7'h7F}; // out 15
    vecs[8]  = '{32'h0000_1000, 32'h0000_0000, 1'b0, 1'b0, 5'd0,  10'h3FF, 7'h7D}; // in 1
    vecs[9]  = '{32'h0000_6000, 32'h0000_0000, 1'b0, 1'b0, 5'd0,  10'h3FF, 7'h3F}; // in 6
    vecs[10] = '{32'h0000_4000, 32'h0000_0000, 1'b0, 1'b0, 5'd0,  10'h3FF, 7'h7F}; // in 4
    vecs[11] = '{32'h0000_7000, 32'h0000_0000, 1'b0, 1'b0, 5'd0,  10'h3FF, 7'h7F}; // in 7
    vecs[12] = '{32'h0000_1500, 32'h0000_0000, 1'b1, 1'b0, 5'd0,  10'h3DF, 7'h7F}; // stall
    vecs[13] = '{32'h0000_1000, 32'h0000_0000, 1'b0, 1'b1, 5'd0,  10'h3FF, 7'h7F}; // not booted

    // ---- reset state with a word that would otherwise drive and strobe ----
    use_model   = 1'b0;
    ucode_force = 32'h0000_1300;
    n_booted    = 1'b0;
    n_rdy       = 1'b0;
    #3;
    check("reset_addr",  32'(sif.ADDR),  32'h000);
    check("reset_fault", 32'(sif.FAULT), 32'h0);
    check("reset_n_out", 32'(sif.N_OUT), 32'h3FF);
    check("reset_n_in",  32'(sif.N_IN),  32'h7F);
    N_RST = 1'b1;

    // ---- table-driven decode ----
    for (int i = 0; i < 14; i++) begin
      step();
      ucode_force = vecs[i].ucode;
      opword      = vecs[i].opword;
      n_rdy       = vecs[i].n_rdy;
      n_booted    = vecs[i].n_booted;
      #2;
      check($sformatf("vec%0d_reg_idx", i), 32'(sif.REG_IDX), 32'(vecs[i].reg_idx));
      check($sformatf("vec%0d_n_out", i),   32'(sif.N_OUT),   32'(vecs[i].n_out));
      check($sformatf("vec%0d_n_in", i),    32'(sif.N_IN),    32'(vecs[i].n_in));
    end

    // ---- reset then boot hold ----
    step();
    N_RST     = 1'b0;
    use_model = 1'b1;
    n_booted  = 1'b1;
    n_rdy     = 1'b0;
    opword    = 32'h0843_1234;
    bus       = 32'h0000_0001;
    #2;
    N_RST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("boot_hold%0d_addr", i), 32'(sif.ADDR), 32'h000);
      check($sformatf("boot_hold%0d_n_in", i), 32'(sif.N_IN), 32'h7F);
    end
    n_booted = 1'b0;
    #1;
    check("boot_addr0",   32'(sif.ADDR), 32'h000);
    check("boot_n_in0",   32'(sif.N_IN), 32'h7D);
    step();
    check("boot_addr1",   32'(sif.ADDR), 32'h001);
    step();
    check("boot_fetch0",  32'(sif.ADDR), 32'h020);

    // ---- fetch, with a stall at step 2 ----
    step();
    check("fetch1",       32'(sif.ADDR), 32'h021);
    step();
    check("fetch2",       32'(sif.ADDR), 32'h022);
    check("fetch2_n_out", 32'(sif.N_OUT), 32'h3F7);
    n_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall%0d_addr", i),  32'(sif.ADDR),  32'h022);
      check($sformatf("stall%0d_n_in", i),  32'(sif.N_IN),  32'h7F);
      check($sformatf("stall%0d_n_out", i), 32'(sif.N_OUT), 32'h3F7);
    end
    n_rdy = 1'b0;
    step();
    check("fetch3",       32'(sif.ADDR), 32'h023);
    step();
    check("fetch4",       32'(sif.ADDR), 32'h024);
    step();
    check("lhu0_addr",    32'(sif.ADDR),    32'h040);
    check("lhu0_reg_idx", 32'(sif.REG_IDX), 32'd2);
    check("lhu0_n_in",    32'(sif.N_IN),    32'h7D);

    // ---- counter overflow ----
    for (int i = 0; i < 31; i++) step();
    check("ovf_last_addr",  32'(sif.ADDR),  32'h05F);
    check("ovf_last_fault", 32'(sif.FAULT), 32'h0);
    step();
    check("ovf_wrap_addr",  32'(sif.ADDR),  32'h000);
    check("ovf_fault",      32'(sif.FAULT), 32'h1);
    step();
    check("post_ovf_addr1", 32'(sif.ADDR),  32'h001);
    step();
    check("post_ovf_fetch", 32'(sif.ADDR),  32'h020);
    check("fault_sticky",   32'(sif.FAULT), 32'h1);

    // ---- asynchronous reset mid-instruction ----
    step(); step(); step();
    check("pre_rst_addr",   32'(sif.ADDR), 32'h023);
    #2;
    N_RST = 1'b0;
    #1;
    check("async_rst_addr",  32'(sif.ADDR),  32'h000);
    check("async_rst_fault", 32'(sif.FAULT), 32'h0);
    N_RST = 1'b1;
    step();
    check("resume_addr",     32'(sif.ADDR),  32'h001);

    // ---- final report ----
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
